led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern sequencer; next generation of the board-level LED chaser.
//  Drives N_LED outputs in one of four run-time selectable patterns: rotate-left,
//  rotate-right, bounce, blink. A prescaler sets the step rate; the rate is
//  divisible at run time. Sits directly under the board top, fed by the fabric clock.
// PARAMETERS
//  N_LED  3        number of LED outputs (>=1)
//  T      1000000  prescaler terminal count; step period = (T>>speed)+1 clk cycles
//  CNT_W  32       prescaler counter width; T must fit in CNT_W bits
// PORTS
//  clk     in   1      system clock, all logic on rising edge
//  resetn  in   1      asynchronous active-low reset
//  en      in   1      1 = run; 0 = freeze counter, pattern and tick
//  mode    in   2      0 ROTL, 1 ROTR, 2 BOUNCE, 3 BLINK
//  speed   in   2      rate select: limit = T >> speed (x1, x2, x4, x8 faster)
//  led     out  N_LED  registered pattern output
//  tick    out  1      one-cycle pulse, high in the cycle led shows a new value
// BEHAVIOUR
//  Reset (async assert, sync release): cnt=0, led=one-hot bit0, dir=LEFT, mode_q=ROTL, tick=0.
//  Prescaler: if en: cnt >= limit -> cnt<=0, step=1; else cnt<=cnt+1. Compare is >=,
//   so lowering limit below current cnt gives a step on the next cycle, never a wrap.
//  tick: registered copy of step; led updates in the same edge, so both change together.
//  en=0: cnt, led, dir, mode_q hold; tick=0. en re-assert resumes from held cnt.
//  Mode change: mode sampled only on step. If mode != mode_q at step: mode_q<=mode,
//   led reloads start pattern (one-hot bit0 for 0-2, all-ones for BLINK), dir<=LEFT;
//   no pattern step that cycle. Otherwise led steps per mode_q:
//   ROTL   led <= {led[N-2:0], led[N-1]}
//   ROTR   led <= {led[0], led[N-1:1]}
//   BOUNCE one-hot moves in dir; at bit N-1 dir<=RIGHT, at bit0 dir<=LEFT; the end
//          bit is shown for exactly one step (0,1,..,N-1,N-2,..,1,0,1..)
//   BLINK  led <= ~led (alternates all-ones / all-zeros)
//  N_LED=1: ROTL/ROTR/BOUNCE hold led=1; BLINK toggles. N_LED=2 BOUNCE = 01,10,01..
//  speed change mid-period: new limit applies from the next cycle; no reset of cnt.
//  Reset mid-period: all state returns to reset values immediately.
// STRUCTURE
//  Package led_pattern_pkg: mode localparams MODE_ROTL/ROTR/BOUNCE/BLINK (2b),
//   DIR_LEFT/DIR_RIGHT, function start_pattern(mode).
//  Sub-module led_tick_prescaler (clk, resetn, en, limit[CNT_W-1:0] -> step): counter +
//   >= compare. Top holds mode_q, dir, led, tick register and next-pattern mux.
//  Elaboration check: N_LED >= 1, T < 2**CNT_W.
// TESTING (T=4, N_LED=4 unless noted)
//  1 Reset, en=1, mode=0, speed=0 -> tick every 5 cycles; led 0001,0010,0100,1000,0001.
//  2 mode=2 for 8 steps -> led 0010,0100,1000,0100,0010,0001,0010,0100; mode=1 at
//    next step -> reload 0001 (no step), then 1000,0100.
//  3 mode=3 -> reload 1111 at next step, then 0000,1111; speed=2 (limit 1) -> tick every 2 cycles.
//  4 speed 0->2 while cnt=3 -> step on next cycle, then period 2; en=0 for 10 cycles ->
//    led, cnt frozen, tick=0; en=1 resumes from frozen cnt.
//  5 Assert resetn=0 mid-period, async (between clk edges) -> led=0001, tick=0 at once;
//    release -> first tick 5 cycles later.
//  6 N_LED=1: modes 0-2 -> led stays 1; mode 3 -> 1,0,1 each step.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode/direction encodings and start-pattern helper for led_pattern_gen.
package led_pattern_pkg;
  localparam logic [1:0] MODE_ROTL   = 2'd0;
  localparam logic [1:0] MODE_ROTR   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  // widest LED bank supported; callers keep the low N_LED bits of start_pattern
  localparam int MAX_LED = 64;
  function automatic logic [MAX_LED-1:0] start_pattern(input logic [1:0] mode);
    return (mode == MODE_BLINK) ? '1 : MAX_LED'(1);
  endfunction
endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: step-rate counter; step is high in the cycle cnt has reached limit.
//  clk    in  1      rising-edge clock
//  resetn in  1      asynchronous active-low reset
//  en     in  1      count enable; step is forced low while 0
//  limit  in  CNT_W  terminal count, may change at any time
//  step   out 1      combinational step request, registered by the parent
module led_tick_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             step
);
  logic [CNT_W-1:0] cnt;
  // >= rather than == so a limit lowered below cnt steps next cycle instead of wrapping
  assign step = en && (cnt >= limit);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (en) cnt <= step ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: run-time selectable LED pattern sequencer (rotl, rotr, bounce, blink).
//  clk    in  1      rising-edge clock
//  resetn in  1      asynchronous active-low reset
//  en     in  1      1 = run, 0 = freeze counter, pattern and tick
//  mode   in  2      0 ROTL, 1 ROTR, 2 BOUNCE, 3 BLINK; sampled on step
//  speed  in  2      step period = (T >> speed) + 1 cycles
//  led    out N_LED  registered pattern
//  tick   out 1      one-cycle pulse with each new led value
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED = 3,
  parameter int T     = 1000000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             tick
);
  if (N_LED < 1 || N_LED > MAX_LED) begin : g_bad_n
    $error("led_pattern_gen: N_LED must be in 1..%0d", MAX_LED);
  end
  if (T < 0 || (CNT_W < 31 && T >= (1 << CNT_W))) begin : g_bad_t
    $error("led_pattern_gen: T does not fit in CNT_W bits");
  end
  logic [CNT_W-1:0]   limit;
  logic               step;
  logic [1:0]         mode_q, mode_d;
  logic               dir, dir_d, turn, go;
  logic [N_LED-1:0]   led_d, rotl, rotr;
  logic [MAX_LED-1:0] start;
  assign limit = CNT_W'(T) >> speed;
  led_tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .limit  (limit),
    .step   (step)
  );
  // modulo indexing keeps N_LED=1 legal: both rotations return led unchanged
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      rotl[i] = led[(i + N_LED - 1) % N_LED];
      rotr[i] = led[(i + 1) % N_LED];
    end
  end
  // bounce turns around when the lit bit already sits at the end it is heading for,
  // so each end bit is shown for exactly one step
  assign turn  = (dir == DIR_LEFT) ? led[N_LED-1] : led[0];
  assign go    = turn ? ~dir : dir;
  assign start = start_pattern(mode);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mode_q <= MODE_ROTL;
      dir    <= DIR_LEFT;
      led    <= N_LED'(1);
      tick   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir    <= dir_d;
      led    <= led_d;
      tick   <= step;
    end
  // a mode change at a step only reloads the start pattern; stepping resumes next step
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir;
    led_d  = led;
    if (step && mode != mode_q) begin
      mode_d = mode;
      dir_d  = DIR_LEFT;
      led_d  = start[N_LED-1:0];
    end else if (step) begin
      led_d = (mode_q == MODE_ROTL)   ? rotl :
              (mode_q == MODE_ROTR)   ? rotr :
              (mode_q == MODE_BOUNCE) ? ((go == DIR_LEFT) ? rotl : rotr) :
                                        ~led;
      dir_d = (mode_q == MODE_BOUNCE) ? go : dir;
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed scoreboard bench for led_pattern_gen (N_LED=4 and N_LED=1, T=4).
module tb_led_pattern_gen;
  typedef struct {
    string tag;
    int    led;
    int    gap;
  } exp_t;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] mode1 = 2'd0;
  logic [1:0] speed = 2'd0;
  logic [3:0] led0;
  logic [0:0] led1;
  logic       tick0, tick1;
  int         errors = 0;
  int         checks = 0;
  exp_t       q[$];
  always #5 clk = ~clk;
  led_pattern_gen #(.N_LED(4), .T(4), .CNT_W(8)) dut4 (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode), .speed(speed), .led(led0), .tick(tick0)
  );
  led_pattern_gen #(.N_LED(1), .T(4), .CNT_W(8)) dut1 (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode1), .speed(speed), .led(led1), .tick(tick1)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input int led, input int gap);
    exp_t e;
    e.tag = tag;
    e.led = led;
    e.gap = gap;
    q.push_back(e);
  endtask
  // wait for the next tick of the selected DUT (bounded), then compare gap and led
  task automatic drain(input bit u);
    while (q.size() > 0) begin
      exp_t e;
      int   n;
      logic t;
      e = q.pop_front();
      n = 0;
      do begin
        @(negedge clk);
        n++;
        t = u ? tick1 : tick0;
      end while (!t && n < 40);
      chk({e.tag, "_gap"}, n, e.gap);
      chk({e.tag, "_led"}, u ? int'(led1) : int'(led0), e.led);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_led", int'(led0), 1);
    chk("rst_tick", int'(tick0), 0);
    resetn = 1'b1;
    push("rotl0", 4'b0010, 5);
    push("rotl1", 4'b0100, 5);
    push("rotl2", 4'b1000, 5);
    push("rotl3", 4'b0001, 5);
    drain(0);
    mode = 2'd2;
    push("bnc_rld", 4'b0001, 5);
    push("bnc0", 4'b0010, 5);
    push("bnc1", 4'b0100, 5);
    push("bnc2", 4'b1000, 5);
    push("bnc3", 4'b0100, 5);
    push("bnc4", 4'b0010, 5);
    push("bnc5", 4'b0001, 5);
    push("bnc6", 4'b0010, 5);
    push("bnc7", 4'b0100, 5);
    drain(0);
    mode = 2'd1;
    push("rotr_rld", 4'b0001, 5);
    push("rotr0", 4'b1000, 5);
    push("rotr1", 4'b0100, 5);
    drain(0);
    mode = 2'd3;
    push("blk_rld", 4'b1111, 5);
    push("blk0", 4'b0000, 5);
    push("blk1", 4'b1111, 5);
    drain(0);
    speed = 2'd2;
    push("fast0", 4'b0000, 2);
    push("fast1", 4'b1111, 2);
    drain(0);
    speed = 2'd0;
    push("slow0", 4'b0000, 5);
    drain(0);
    repeat (3) @(negedge clk);
    speed = 2'd2;
    push("late_lim", 4'b1111, 1);
    push("late_lim2", 4'b0000, 2);
    drain(0);
    speed = 2'd0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("frz_tick", int'(tick0), 0);
      chk("frz_led", int'(led0), 4'b0000);
    end
    en = 1'b1;
    push("resume", 4'b1111, 3);
    drain(0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_led", int'(led0), 1);
    chk("arst_tick", int'(tick0), 0);
    mode = 2'd0;
    @(negedge clk);
    resetn = 1'b1;
    push("post_rst", 4'b0010, 5);
    drain(0);
    push("n1_rotl", 1, 5);
    drain(1);
    mode1 = 2'd1;
    push("n1_rotr_rld", 1, 5);
    push("n1_rotr", 1, 5);
    drain(1);
    mode1 = 2'd2;
    push("n1_bnc_rld", 1, 5);
    push("n1_bnc0", 1, 5);
    push("n1_bnc1", 1, 5);
    drain(1);
    mode1 = 2'd3;
    push("n1_blk_rld", 1, 5);
    push("n1_blk0", 0, 5);
    push("n1_blk1", 1, 5);
    drain(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
